uart_rx_frame: RTL and testbench

//  UART receiver stage fed by the baud controller's sample_ENABLE tick at 16x baud.
//  - Synchronises the serial line RxD.
//  - Detects and validates the start bit, then majority-samples data, parity and stop bits.
//  - Delivers one parallel byte per frame, with status pulses.
//  - Sits between the baud controller and the receive-side consumer logic.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/rx_bit_sampler.sv | 36 +++
 rtl/uart_rx_frame.sv | 118 +++++++++++
 tb/tb_uart_rx_frame.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and constants for the receive path and the baud controller.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam logic [3:0] SAMPLE_MID = 4'd7;
    localparam logic [3:0] SAMPLE_END = 4'd15;

    // Baud select codes understood by the baud controller
    localparam logic [1:0] BAUD_SEL_9600   = 2'd0;
    localparam logic [1:0] BAUD_SEL_19200  = 2'd1;
    localparam logic [1:0] BAUD_SEL_57600  = 2'd2;
    localparam logic [1:0] BAUD_SEL_115200 = 2'd3;

endpackage

// File: rtl/rx_bit_sampler.sv
// RxD synchroniser plus 3-sample majority voter over the middle of each bit.
module rx_bit_sampler
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_tick,
    input  logic [3:0] i_sample_cnt,
    input  logic       i_rxd,
    output logic       o_rxd_s,
    output logic       o_bit_val
);

    logic [1:0] r_sync;
    logic       r_s0;
    logic       r_s1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync <= 2'b11;
            r_s0   <= 1'b1;
            r_s1   <= 1'b1;
        end else begin
            r_sync <= {r_sync[0], i_rxd};
            if (i_tick && (i_sample_cnt == SAMPLE_MID))
                r_s0 <= r_sync[1];
            if (i_tick && (i_sample_cnt == SAMPLE_MID + 4'd1))
                r_s1 <= r_sync[1];
        end
    end

    assign o_rxd_s = r_sync[1];
    // Third vote is the live sample, so the result is ready on the tick-9 edge
    assign o_bit_val = (r_s0 & r_s1) | (r_s0 & r_sync[1]) | (r_s1 & r_sync[1]);

endmodule

// File: rtl/uart_rx_frame.sv
// UART frame receiver: start validation, data/parity/stop sampling, status pulses.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_ENABLE,
    input  logic                 Rx_EN,
    input  logic                 RxD,
    output logic [DATA_BITS-1:0] Rx_DATA,
    output logic                 Rx_VALID,
    output logic                 Rx_PERROR,
    output logic                 Rx_FERROR
);

    localparam int              BC_W      = $clog2(DATA_BITS);
    localparam logic [3:0]      TICK_END  = 4'(OVERSAMPLE - 1);
    localparam logic [3:0]      TICK_VOTE = SAMPLE_MID + 4'd2;
    localparam logic [BC_W-1:0] BIT_LAST  = BC_W'(DATA_BITS - 1);

    rx_state_t             r_state;
    logic [3:0]            r_sample_cnt;
    logic [BC_W-1:0]       r_bit_cnt;
    logic [DATA_BITS-1:0]  r_shift;
    logic                  r_par_rx;
    logic                  w_rxd_s;
    logic                  w_bit_val;
    logic                  w_perr;
    logic                  w_ferr;

    rx_bit_sampler u_sampler (
        .clk          (clk),
        .reset        (reset),
        .i_tick       (sample_ENABLE),
        .i_sample_cnt (r_sample_cnt),
        .i_rxd        (RxD),
        .o_rxd_s      (w_rxd_s),
        .o_bit_val    (w_bit_val)
    );

    assign w_perr = (PARITY_EN != 0) && (r_par_rx != ^r_shift);
    assign w_ferr = !w_bit_val;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_sample_cnt <= 4'd0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_par_rx     <= 1'b0;
            Rx_DATA      <= '0;
            Rx_VALID     <= 1'b0;
            Rx_PERROR    <= 1'b0;
            Rx_FERROR    <= 1'b0;
        end else begin
            Rx_VALID  <= 1'b0;
            Rx_PERROR <= 1'b0;
            Rx_FERROR <= 1'b0;
            if (!Rx_EN) begin
                r_state      <= IDLE;
                r_sample_cnt <= 4'd0;
                r_bit_cnt    <= '0;
            end else if (sample_ENABLE) begin
                r_sample_cnt <= (r_sample_cnt == TICK_END) ? 4'd0 : r_sample_cnt + 4'd1;
                case (r_state)
                    IDLE: begin
                        r_sample_cnt <= 4'd0;
                        if (!w_rxd_s)
                            r_state <= START;
                    end
                    START: begin
                        if ((r_sample_cnt == SAMPLE_MID) && w_rxd_s) begin
                            r_state      <= IDLE;
                            r_sample_cnt <= 4'd0;
                        end else if (r_sample_cnt == TICK_END) begin
                            r_state   <= DATA;
                            r_bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        if (r_sample_cnt == TICK_VOTE)
                            r_shift <= {w_bit_val, r_shift[DATA_BITS-1:1]};
                        if (r_sample_cnt == TICK_END) begin
                            if (r_bit_cnt == BIT_LAST)
                                r_state <= (PARITY_EN != 0) ? PARITY : STOP;
                            else
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                    PARITY: begin
                        if (r_sample_cnt == TICK_VOTE)
                            r_par_rx <= w_bit_val;
                        if (r_sample_cnt == TICK_END)
                            r_state <= STOP;
                    end
                    STOP: begin
                        // Leave mid-stop-bit so a 1-bit stop still allows back-to-back frames
                        if (r_sample_cnt == TICK_VOTE) begin
                            Rx_DATA      <= r_shift;
                            Rx_PERROR    <= w_perr;
                            Rx_FERROR    <= w_ferr;
                            Rx_VALID     <= !w_perr && !w_ferr;
                            r_state      <= IDLE;
                            r_sample_cnt <= 4'd0;
                            r_bit_cnt    <= '0;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Scoreboard bench for uart_rx_frame: directed frames plus random frames vs a frame-level model.
module tb_uart_rx_frame;

    localparam int BIT_CLK = 320;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sample_ENABLE = 1'b0;
    logic       Rx_EN = 1'b0;
    logic       RxD = 1'b1;
    logic [7:0] Rx_DATA;
    logic       Rx_VALID;
    logic       Rx_PERROR;
    logic       Rx_FERROR;

    typedef struct packed {
        logic [7:0] data;
        logic       valid;
        logic       perr;
        logic       ferr;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         failures = 0;
    int         tick_ph = 0;
    logic [7:0] exp_last = 8'h00;

    uart_rx_frame #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1)) dut (
        .clk           (clk),
        .reset         (reset),
        .sample_ENABLE (sample_ENABLE),
        .Rx_EN         (Rx_EN),
        .RxD           (RxD),
        .Rx_DATA       (Rx_DATA),
        .Rx_VALID      (Rx_VALID),
        .Rx_PERROR     (Rx_PERROR),
        .Rx_FERROR     (Rx_FERROR)
    );

    always #10 clk = ~clk;

    // One tick every 20 clocks
    initial forever begin
        @(posedge clk);
        #1;
        tick_ph = (tick_ph == 19) ? 0 : tick_ph + 1;
        sample_ENABLE = (tick_ph == 0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Every pulse cycle must match the next expected frame; a 2-cycle pulse pops twice
    always @(negedge clk) begin
        exp_t e;
        exp_t a;
        if (reset && (Rx_VALID || Rx_PERROR || Rx_FERROR)) begin
            a = {Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR};
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pulse actual=%h required=none", a);
            end else begin
                e = sb.pop_front();
                if (a !== e) begin
                    failures++;
                    $display("FAIL frame actual data=%h v/p/f=%b%b%b required data=%h v/p/f=%b%b%b",
                             a.data, a.valid, a.perr, a.ferr, e.data, e.valid, e.perr, e.ferr);
                end
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Start edge placed 10 clocks before a tick, so tick k of bit b lands at 10+20*(16b+k)
    task automatic align();
        do begin
            @(posedge clk);
            #2;
        end while (tick_ph != 11);
    endtask

    task automatic drive_bit(input logic b, input logic corrupt);
        RxD = b;
        if (corrupt) begin
            wait_clk(150);
            RxD = ~b;
            wait_clk(20);
            RxD = b;
            wait_clk(150);
        end else begin
            wait_clk(BIT_CLK);
        end
    endtask

    task automatic idle(input int nbits);
        repeat (nbits) drive_bit(1'b1, 1'b0);
    endtask

    task automatic expect_frame(input logic [7:0] d, input logic par_bit, input logic stop_bit);
        exp_t e;
        e.data  = d;
        e.perr  = (par_bit != ^d);
        e.ferr  = (stop_bit == 1'b0);
        e.valid = !e.perr && !e.ferr;
        sb.push_back(e);
        exp_last = d;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic flip_par, input logic stop_bit,
                              input int corrupt_bit, input int abort_after);
        logic par;
        par = (^d) ^ flip_par;
        if (abort_after < 0)
            expect_frame(d, par, stop_bit);
        align();
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            drive_bit(d[i], i == corrupt_bit);
            if (i == abort_after)
                Rx_EN = 1'b0;
        end
        drive_bit(par, 1'b0);
        drive_bit(stop_bit, 1'b0);
    endtask

    initial begin
        logic [7:0] rd;
        logic       rf;
        logic       rs;
        int         rc;

        #1 reset = 1'b0;
        #4;
        chk("reset_outputs", {Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR}, 32'h0);
        wait_clk(3);
        reset = 1'b1;
        Rx_EN = 1'b1;
        idle(1);

        send_frame(8'hA5, 1'b0, 1'b1, -1, -1);
        idle(1);
        send_frame(8'h3C, 1'b1, 1'b1, -1, -1);
        idle(1);

        // Break: stop bit low, line stays low for one more full frame, released in the next START
        send_frame(8'hFF, 1'b0, 1'b0, -1, -1);
        expect_frame(8'h00, 1'b0, 1'b0);
        wait_clk(3330);
        RxD = 1'b1;
        idle(2);

        align();
        RxD = 1'b0;
        wait_clk(60);
        RxD = 1'b1;
        idle(1);
        send_frame(8'h6B, 1'b0, 1'b1, 2, -1);
        idle(1);

        send_frame(8'h55, 1'b0, 1'b1, -1, 3);
        idle(1);
        chk("abort_hold_data", {24'h0, Rx_DATA}, {24'h0, exp_last});
        chk("abort_no_pending", sb.size(), 0);
        Rx_EN = 1'b1;
        idle(1);
        send_frame(8'h81, 1'b0, 1'b1, -1, -1);
        idle(1);

        align();
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b0, 1'b0);
        reset = 1'b0;
        #3;
        chk("reset_mid_frame", {Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR}, 32'h0);
        RxD = 1'b1;
        wait_clk(5);
        reset = 1'b1;
        exp_last = 8'h00;
        idle(1);
        send_frame(8'h12, 1'b0, 1'b1, -1, -1);
        send_frame(8'h34, 1'b0, 1'b1, -1, -1);
        idle(1);
        chk("b2b_last_data", {24'h0, Rx_DATA}, {24'h0, exp_last});

        for (int n = 0; n < 8; n++) begin
            rd = 8'($urandom_range(0, 255));
            rf = ($urandom_range(0, 3) == 0);
            rs = ($urandom_range(0, 4) != 0);
            rc = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : -1;
            send_frame(rd, rf, rs, rc, -1);
            idle(1);
        end

        for (int i = 0; i < 5000 && sb.size() != 0; i++)
            @(posedge clk);
        chk("scoreboard_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
